mem_access_stage: RTL and testbench

- Memory-stage controller. Consumes the EX/MEM pipeline register outputs, runs a req/ack handshake to data memory for loads and stores, and produces write-back fields for the MEM/WB register.
- Drives a stall signal that gates the EX/MEM register enable and upstream enables while a memory access is outstanding.

---
 rtl/mem_access_stage.sv | 178 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage
// ----------------
// Memory-stage controller that sits between the EX/MEM and MEM/WB pipeline
// registers. Loads and stores are issued to data memory through a req/ack
// handshake. A write-back result is produced for the MEM/WB register. While an
// access is outstanding, the stall output holds EX/MEM and every earlier stage.
//
// All state changes on the falling edge of clk, the same edge the pipeline
// registers use. reset is asynchronous and active-low.
//
// Optional feature: define MEM_TIMEOUT_EN to abort an access that has seen no
// ack after TIMEOUT_CYCLES cycles in ACCESS. An abort sets the sticky mem_err
// flag. Without the macro, ACCESS waits indefinitely and mem_err is tied 0.
//
// Ports
//   clk, reset            clock (negedge active), async active-low reset
//   in_*                  EX/MEM register fields (data and control)
//   mem_req/we/addr/wdata request side of the data-memory handshake
//   mem_ack/mem_rdata     one-cycle completion strobe and load data
//   stall                 hold EX/MEM and upstream stages
//   out_wba/out_wb_data/out_regWen  fields for the MEM/WB register
//   mem_err               sticky timeout flag
module mem_access_stage #(
  parameter int         ADDR_W         = 32,
  parameter logic [3:0] PIXEL_TYPE     = 4'd7,
  parameter logic [4:0] LINK_REG       = 5'd31,
  parameter int         TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        in_wba,
  input  logic [31:0]       in_A,
  input  logic [31:0]       in_B,
  input  logic [31:0]       in_ALUresult,
  input  logic [31:0]       in_nextPC,
  input  logic [31:0]       in_color,
  input  logic              in_MemtoReg,
  input  logic              in_MemWrite,
  input  logic              in_MemAddrSrc,
  input  logic              in_WBaddrSelect,
  input  logic              in_regWen,
  input  logic [3:0]        in_InstrType,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              stall,
  output logic [4:0]        out_wba,
  output logic [31:0]       out_wb_data,
  output logic              out_regWen,
  output logic              mem_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [4:0]  wba_reg, wba_next;
  logic [31:0] wb_data_reg, wb_data_next;
  logic        regwen_reg, regwen_next;

  logic        memop;
  logic [31:0] sel_addr;
  logic [4:0]  wb_target;
  logic [31:0] wb_value;

  assign memop     = in_MemtoReg | in_MemWrite;
  assign sel_addr  = in_MemAddrSrc ? in_A : in_ALUresult;
  assign wb_target = in_WBaddrSelect ? LINK_REG : in_wba;
  // A store wins over a load when both controls are set, so load data is
  // returned only for a pure load.
  assign wb_value  = in_WBaddrSelect ? in_nextPC :
                     ((in_MemtoReg & ~in_MemWrite) ? mem_rdata : in_ALUresult);

  // mem_req depends only on the state register. An asynchronous reset
  // therefore drops the request at once, even in the middle of an access.
  assign mem_req   = (state_reg == ACCESS);
  assign mem_we    = in_MemWrite;
  assign mem_addr  = sel_addr[ADDR_W-1:0];
  assign mem_wdata = (in_InstrType == PIXEL_TYPE) ? in_color : in_B;
  assign stall     = ((state_reg == IDLE) & memop) | (state_reg == ACCESS);

  assign out_wba     = wba_reg;
  assign out_wb_data = wb_data_reg;
  assign out_regWen  = regwen_reg;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             err_reg, err_next;
  assign mem_err = err_reg;
`else
  assign mem_err = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    wba_next     = wba_reg;
    wb_data_next = wb_data_reg;
    // Every edge that does not write a result inserts a bubble.
    regwen_next  = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_next     = cnt_reg;
    err_next     = err_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (memop) begin
          state_next = ACCESS;
`ifdef MEM_TIMEOUT_EN
          cnt_next   = '0;
`endif
        end else begin
          wba_next     = wb_target;
          wb_data_next = wb_value;
          regwen_next  = in_regWen;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_next   = RESP;
          wba_next     = wb_target;
          wb_data_next = wb_value;
          regwen_next  = in_regWen;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // This is the last cycle of the timeout window. Abort the access and
          // retire the instruction with a zero result.
          state_next   = RESP;
          err_next     = 1'b1;
          wba_next     = wb_target;
          wb_data_next = 32'd0;
          regwen_next  = in_regWen;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
`endif
      end
      // RESP lasts exactly one cycle. EX/MEM advances on the edge that leaves
      // RESP, so the completed op is never seen again in IDLE.
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      wba_reg     <= 5'd0;
      wb_data_reg <= 32'd0;
      regwen_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      wba_reg     <= wba_next;
      wb_data_reg <= wb_data_next;
      regwen_reg  <= regwen_next;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      err_reg <= err_next;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage. The DUT updates on negedge clk.
// Inputs are driven, and outputs sampled, 1 time unit after each posedge.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  in_wba;
  logic [31:0] in_A, in_B, in_ALUresult, in_nextPC, in_color;
  logic        in_MemtoReg, in_MemWrite, in_MemAddrSrc, in_WBaddrSelect, in_regWen;
  logic [3:0]  in_InstrType;
  logic        mem_req, mem_we, mem_ack, stall, out_regWen, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, out_wb_data;
  logic [4:0]  out_wba;

  mem_access_stage #(
    .ADDR_W(32), .PIXEL_TYPE(4'd7), .LINK_REG(5'd31), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset),
    .in_wba(in_wba), .in_A(in_A), .in_B(in_B), .in_ALUresult(in_ALUresult),
    .in_nextPC(in_nextPC), .in_color(in_color),
    .in_MemtoReg(in_MemtoReg), .in_MemWrite(in_MemWrite),
    .in_MemAddrSrc(in_MemAddrSrc), .in_WBaddrSelect(in_WBaddrSelect),
    .in_regWen(in_regWen), .in_InstrType(in_InstrType),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .out_wba(out_wba), .out_wb_data(out_wb_data),
    .out_regWen(out_regWen), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [4:0]  wba;
    logic [31:0] a, b, alu, npc, color;
    logic        m2r, mw, asrc, wbsel, rwen;
    logic [3:0]  itype;
    int          ack_delay;
    logic [31:0] rdata;
    logic [31:0] e_addr, e_wdata;
    logic        e_we;
    logic [4:0]  e_wba;
    logic [31:0] e_data;
    logic        e_rwen;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    in_wba = 0; in_A = 0; in_B = 0; in_ALUresult = 0; in_nextPC = 0; in_color = 0;
    in_MemtoReg = 0; in_MemWrite = 0; in_MemAddrSrc = 0; in_WBaddrSelect = 0;
    in_regWen = 0; in_InstrType = 0;
  endtask

  task automatic drive(input vec_t v);
    in_wba = v.wba; in_A = v.a; in_B = v.b; in_ALUresult = v.alu;
    in_nextPC = v.npc; in_color = v.color; in_MemtoReg = v.m2r;
    in_MemWrite = v.mw; in_MemAddrSrc = v.asrc; in_WBaddrSelect = v.wbsel;
    in_regWen = v.rwen; in_InstrType = v.itype;
  endtask

  task automatic run_vec(input vec_t v);
    logic memop;
    bit   acked;
    memop = v.m2r | v.mw;
    acked = 0;
    step();
    drive(v);
    #1;
    chk({v.name, " stall_idle"}, stall, memop);
    chk({v.name, " req_idle"}, mem_req, 0);
    if (memop) begin
      chk({v.name, " addr"}, mem_addr, v.e_addr);
      chk({v.name, " wdata"}, mem_wdata, v.e_wdata);
      chk({v.name, " we"}, mem_we, v.e_we);
      for (int k = 1; k <= 40; k++) begin
        step();
        chk({v.name, " req_access"}, mem_req, 1);
        chk({v.name, " stall_access"}, stall, 1);
        chk({v.name, " regwen_bubble"}, out_regWen, 0);
        if (k == v.ack_delay) begin
          mem_ack = 1; mem_rdata = v.rdata;
          step();
          mem_ack = 0; mem_rdata = 32'hDEADBEEF;
          acked = 1;
          break;
        end
      end
      if (!acked) chk({v.name, " ack_bound"}, 0, 1);
      // RESP cycle: the result has been written
      chk({v.name, " req_resp"}, mem_req, 0);
      chk({v.name, " stall_resp"}, stall, 0);
      chk({v.name, " wba"}, out_wba, v.e_wba);
      chk({v.name, " wb_data"}, out_wb_data, v.e_data);
      chk({v.name, " regwen"}, out_regWen, v.e_rwen);
      nop();
      step();
      chk({v.name, " req_after"}, mem_req, 0);
      chk({v.name, " regwen_once"}, out_regWen, 0);
      chk({v.name, " data_hold"}, out_wb_data, v.e_data);
    end else begin
      step();
      chk({v.name, " stall"}, stall, 0);
      chk({v.name, " wba"}, out_wba, v.e_wba);
      chk({v.name, " wb_data"}, out_wb_data, v.e_data);
      chk({v.name, " regwen"}, out_regWen, v.e_rwen);
    end
    $display("vec %-10s wba=%0d wb_data=%h regWen=%b", v.name, out_wba, out_wb_data, out_regWen);
  endtask

  function automatic vec_t mk(input string name, input logic [4:0] wba,
      input logic [31:0] a, b, alu, npc, color,
      input logic m2r, mw, asrc, wbsel, rwen, input logic [3:0] itype,
      input int ack_delay, input logic [31:0] rdata,
      input logic [31:0] e_addr, e_wdata, input logic e_we,
      input logic [4:0] e_wba, input logic [31:0] e_data, input logic e_rwen);
    vec_t v;
    v.name = name; v.wba = wba; v.a = a; v.b = b; v.alu = alu; v.npc = npc;
    v.color = color; v.m2r = m2r; v.mw = mw; v.asrc = asrc; v.wbsel = wbsel;
    v.rwen = rwen; v.itype = itype; v.ack_delay = ack_delay; v.rdata = rdata;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_we = e_we; v.e_wba = e_wba;
    v.e_data = e_data; v.e_rwen = e_rwen;
    return v;
  endfunction

  initial begin
    //               name     wba   A             B             ALU           nextPC      color        m2r mw asrc wbs rwen ity dly rdata         e_addr        e_wdata       we e_wba e_data        rwen
    vecs[0] = mk("alu",     5'd5, 32'h0,        32'h0,        32'h1234,     32'h0,      32'h0,       0, 0, 0, 0, 1, 4'd0, 0, 32'h0,        32'h0,        32'h0,        0, 5'd5,  32'h1234,     1);
    vecs[1] = mk("link",    5'd3, 32'h0,        32'h0,        32'h55,       32'h104,    32'h0,       0, 0, 0, 1, 1, 4'd0, 0, 32'h0,        32'h0,        32'h0,        0, 5'd31, 32'h104,      1);
    vecs[2] = mk("alu_nowe",5'd9, 32'h0,        32'h0,        32'hAAAA5555, 32'h0,      32'h0,       0, 0, 0, 0, 0, 4'd0, 0, 32'h0,        32'h0,        32'h0,        0, 5'd9,  32'hAAAA5555, 0);
    vecs[3] = mk("load",    5'd7, 32'h999,      32'h77,       32'h40,       32'h0,      32'h0,       1, 0, 0, 0, 1, 4'd0, 3, 32'hCAFE,     32'h40,       32'h77,       0, 5'd7,  32'hCAFE,     1);
    vecs[4] = mk("pixel_st",5'd0, 32'h800,      32'h1,        32'h10,       32'h0,      32'hFF00FF,  0, 1, 1, 0, 0, 4'd7, 1, 32'h1111,     32'h800,      32'hFF00FF,   1, 5'd0,  32'h10,       0);
    vecs[5] = mk("store",   5'd2, 32'h0,        32'h12345678, 32'h20,       32'h0,      32'hABC,     0, 1, 0, 0, 0, 4'd2, 2, 32'h2222,     32'h20,       32'h12345678, 1, 5'd2,  32'h20,       0);
    vecs[6] = mk("ld_st",   5'd4, 32'h0,        32'h5,        32'h30,       32'h0,      32'h0,       1, 1, 0, 0, 1, 4'd0, 1, 32'hBAD,      32'h30,       32'h5,        1, 5'd4,  32'h30,       1);
    vecs[7] = mk("ld_link", 5'd6, 32'h0,        32'h0,        32'h44,       32'h200,    32'h0,       1, 0, 0, 1, 1, 4'd0, 2, 32'h5A5A,     32'h44,       32'h0,        0, 5'd31, 32'h200,      1);
    vecs[8] = mk("alu_max", 5'd17,32'h0,        32'h0,        32'hFFFFFFFF, 32'h0,      32'h0,       0, 0, 0, 0, 1, 4'd0, 0, 32'h0,        32'h0,        32'h0,        0, 5'd17, 32'hFFFFFFFF, 1);

    // Reset state
    reset = 0; mem_ack = 0; mem_rdata = 32'hDEADBEEF;
    nop();
    #2;
    chk("rst req", mem_req, 0);
    chk("rst stall", stall, 0);
    chk("rst wba", out_wba, 0);
    chk("rst data", out_wb_data, 0);
    chk("rst regwen", out_regWen, 0);
    chk("rst err", mem_err, 0);
    step();
    reset = 1;
    $display("reset released");

    foreach (vecs[i]) run_vec(vecs[i]);

    // mem_ack outside ACCESS is ignored
    step();
    in_ALUresult = 32'h77; in_wba = 5'd8; in_regWen = 1;
    mem_ack = 1; mem_rdata = 32'hEEEE;
    step();
    mem_ack = 0; mem_rdata = 32'hDEADBEEF;
    chk("stray_ack req", mem_req, 0);
    chk("stray_ack data", out_wb_data, 32'h77);
    chk("stray_ack regwen", out_regWen, 1);
    $display("stray ack: wb_data=%h req=%b", out_wb_data, mem_req);
    nop();

`ifdef MEM_TIMEOUT_EN
    // No ack: abort after 4 ACCESS cycles
    step();
    in_MemtoReg = 1; in_ALUresult = 32'h60; in_wba = 5'd12; in_regWen = 1;
    begin
      int req_cycles;
      req_cycles = 0;
      for (int k = 0; k < 12; k++) begin
        step();
        if (mem_req) req_cycles++;
        else break;
      end
      chk("timeout req_cycles", req_cycles, 4);
    end
    chk("timeout err", mem_err, 1);
    chk("timeout data", out_wb_data, 0);
    chk("timeout regwen", out_regWen, 1);
    chk("timeout wba", out_wba, 12);
    nop();
    step();
    step();
    chk("timeout err_sticky", mem_err, 1);
    chk("timeout no_reissue", mem_req, 0);
    $display("timeout: err=%b wb_data=%h", mem_err, out_wb_data);
`else
    // No ack: the request is held indefinitely and no error is flagged
    step();
    in_MemtoReg = 1; in_ALUresult = 32'h60; in_wba = 5'd12; in_regWen = 1;
    repeat (20) step();
    chk("noack req_held", mem_req, 1);
    chk("noack stall", stall, 1);
    chk("noack err", mem_err, 0);
    mem_ack = 1; mem_rdata = 32'h6060;
    step();
    mem_ack = 0;
    chk("noack late_data", out_wb_data, 32'h6060);
    nop();
    step();
    $display("no-ack wait: late data=%h", out_wb_data);
`endif

    // Reset asserted mid-ACCESS
    step();
    in_MemtoReg = 1; in_ALUresult = 32'h90; in_wba = 5'd1; in_regWen = 1;
    step();
    chk("midrst req_before", mem_req, 1);
    #1 reset = 0;
    #1;
    chk("midrst req", mem_req, 0);
    chk("midrst regwen", out_regWen, 0);
    chk("midrst data", out_wb_data, 0);
    chk("midrst err", mem_err, 0);
    nop();
    step();
    reset = 1;
    step();
    chk("midrst no_retry", mem_req, 0);
    chk("midrst stall", stall, 0);
    // Back in IDLE: an ALU op completes in one edge
    in_ALUresult = 32'h4321; in_wba = 5'd11; in_regWen = 1;
    step();
    chk("midrst alu_data", out_wb_data, 32'h4321);
    chk("midrst alu_regwen", out_regWen, 1);
    $display("mid-access reset: recovered wb_data=%h", out_wb_data);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
